// File: rtl/clock_set_controller.sv
// Mode/sequencing controller for a time-of-day clock: 1 Hz tick in RUN, field select in SET,
// debounced auto-repeating inc/dec keys and a digit blink enable. All outputs are registered.
module clock_set_controller #(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_RATE     = 5_000_000,
  parameter int unsigned BLINK_DIV       = 12_500_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       set_sw,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_next,
  output logic       run,
  output logic       tick_sec,
  output logic [1:0] field_sel,
  output logic       inc,
  output logic       dec,
  output logic       blink_on
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(RPT_MAX);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  // Encoding doubles as the field_sel value.
  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_SEC  = 2'b01,
    S_MIN  = 2'b10,
    S_HOUR = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]           deb_q, deb_d, prev_q, prev_d;
  logic [2:0][DW-1:0]   dcnt_q, dcnt_d;
  logic [TW-1:0]        presc_q, presc_d;
  logic [RW-1:0]        rpt_cnt_q, rpt_cnt_d;
  logic                 rpt_up_q, rpt_up_d, rpt_dn_q, rpt_dn_d, rpt_fast_q, rpt_fast_d;
  logic                 lock_q, lock_d;
  logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
  logic                 run_q, run_d, tick_q, tick_d, inc_q, inc_d, dec_q, dec_d;
  logic                 blink_q, blink_d;
  logic [1:0]           field_q, field_d;

  logic [2:0]           press, held;
  logic                 both, allow;
  logic [RW-1:0]        rpt_last;

  // Key bit order: 0 up, 1 down, 2 next; keys are active-low.
  always_comb begin
    sync1_d = {key_next, key_down, key_up};
    sync2_d = sync1_q;
    prev_d  = deb_q;
    deb_d   = deb_q;
    dcnt_d  = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else dcnt_d[i] = dcnt_q[i] + DW'(1);
      end
    end
  end

  assign press = prev_q & ~deb_q;
  assign held  = ~deb_q;
  assign both  = held[0] & held[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:  if (set_sw) state_d = S_HOUR;
      S_HOUR: if (!set_sw) state_d = S_RUN; else if (press[2]) state_d = S_MIN;
      S_MIN:  if (!set_sw) state_d = S_RUN; else if (press[2]) state_d = S_SEC;
      S_SEC:  if (!set_sw) state_d = S_RUN; else if (press[2]) state_d = S_HOUR;
      default: state_d = S_RUN;
    endcase
    run_d   = (state_d == S_RUN);
    field_d = state_d;
  end

  // Prescaler restarts whenever RUN is (re)entered.
  always_comb begin
    tick_d  = 1'b0;
    presc_d = '0;
    if (state_d == S_RUN && state_q == S_RUN) begin
      if (presc_q == TICK_LAST) tick_d = 1'b1;
      else presc_d = presc_q + TW'(1);
    end
  end

  // Pulses only in a stable SET field with no up/down chord outstanding.
  always_comb begin
    allow      = (state_q != S_RUN) && (state_d == state_q) && !both && !lock_q;
    rpt_last   = rpt_fast_q ? RATE_LAST : DELAY_LAST;
    inc_d      = 1'b0;
    dec_d      = 1'b0;
    rpt_up_d   = 1'b0;
    rpt_dn_d   = 1'b0;
    rpt_fast_d = 1'b0;
    rpt_cnt_d  = '0;
    if (both) lock_d = 1'b1;
    else if (!held[0] && !held[1]) lock_d = 1'b0;
    else lock_d = lock_q;
    if (allow) begin
      if (press[0]) begin
        inc_d    = 1'b1;
        rpt_up_d = 1'b1;
      end else if (press[1]) begin
        dec_d    = 1'b1;
        rpt_dn_d = 1'b1;
      end else if ((rpt_up_q && held[0]) || (rpt_dn_q && held[1])) begin
        rpt_up_d   = rpt_up_q;
        rpt_dn_d   = rpt_dn_q;
        rpt_fast_d = rpt_fast_q;
        if (rpt_cnt_q == rpt_last) begin
          inc_d      = rpt_up_q;
          dec_d      = rpt_dn_q;
          rpt_fast_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RW'(1);
        end
      end
    end
  end

  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (state_d == S_RUN || state_d != state_q || inc_d || dec_d) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RUN;
      sync1_q     <= '1;
      sync2_q     <= '1;
      deb_q       <= '1;
      prev_q      <= '1;
      dcnt_q      <= '0;
      presc_q     <= '0;
      rpt_cnt_q   <= '0;
      rpt_up_q    <= 1'b0;
      rpt_dn_q    <= 1'b0;
      rpt_fast_q  <= 1'b0;
      lock_q      <= 1'b0;
      blink_cnt_q <= '0;
      run_q       <= 1'b0;
      tick_q      <= 1'b0;
      field_q     <= 2'b00;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      blink_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      prev_q      <= prev_d;
      dcnt_q      <= dcnt_d;
      presc_q     <= presc_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_up_q    <= rpt_up_d;
      rpt_dn_q    <= rpt_dn_d;
      rpt_fast_q  <= rpt_fast_d;
      lock_q      <= lock_d;
      blink_cnt_q <= blink_cnt_d;
      run_q       <= run_d;
      tick_q      <= tick_d;
      field_q     <= field_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      blink_q     <= blink_d;
    end
  end

  assign run       = run_q;
  assign tick_sec  = tick_q;
  assign field_sel = field_q;
  assign inc       = inc_q;
  assign dec       = dec_q;
  assign blink_on  = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with small divider parameters; outputs are
// sampled on the falling clock edge, cycle index c = number of rising edges since the step began.
module tb_clock_set_controller;

  localparam int TICK_DIV = 10;
  localparam int DEB      = 4;
  localparam int RD       = 20;
  localparam int RR       = 5;
  localparam int BD       = 8;

  logic       clock = 1'b0;
  logic       reset_n, set_sw, key_up, key_down, key_next;
  logic       run, tick_sec, inc, dec, blink_on;
  logic [1:0] field_sel;

  int n_chk  = 0;
  int n_fail = 0;

  clock_set_controller #(
    .TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .BLINK_DIV(BD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .set_sw(set_sw),
    .key_up(key_up), .key_down(key_down), .key_next(key_next),
    .run(run), .tick_sec(tick_sec), .field_sel(field_sel),
    .inc(inc), .dec(dec), .blink_on(blink_on)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       set_sw;
    logic       kn;
    logic [7:0] n;
    logic       e_run;
    logic [1:0] e_field;
    logic       e_tick;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_next();
    key_next = 1'b0;
    cyc(8);
    key_next = 1'b1;
    cyc(8);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " run"}, run, 0);
    chk({tag, " tick"}, tick_sec, 0);
    chk({tag, " field"}, field_sel, 0);
    chk({tag, " inc"}, inc, 0);
    chk({tag, " dec"}, dec, 0);
    chk({tag, " blink"}, blink_on, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_i, bm;
    int   bc;

    reset_n = 1'b0; set_sw = 1'b0;
    key_up = 1'b1; key_down = 1'b1; key_next = 1'b1;
    cyc(3);
    chk_reset_vals("reset");

    // Free-running RUN after reset release: ticks at cycles 10, 20, 30.
    reset_n = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      cyc(1);
      chk($sformatf("t1 run c%0d", c), run, 1);
      chk($sformatf("t1 tick c%0d", c), tick_sec, (c % 10 == 0) ? 1 : 0);
    end

    // Field stepping with key_next; entry 9 drops set_sw on the same edge as a next press.
    tbl[0]  = '{1'b1, 1'b1, 8'd1, 1'b0, 2'd3, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'd6, 1'b0, 2'd3, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'd1, 1'b0, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'd8, 1'b0, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'd7, 1'b0, 2'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'd8, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'd7, 1'b0, 2'd3, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'd8, 1'b0, 2'd3, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'd6, 1'b0, 2'd3, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'd1, 1'b1, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'd9, 1'b1, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8'd1, 1'b1, 2'd0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      set_sw   = tbl[i].set_sw;
      key_next = tbl[i].kn;
      cyc(int'(tbl[i].n));
      chk($sformatf("t2[%0d] run", i), run, tbl[i].e_run);
      chk($sformatf("t2[%0d] field", i), field_sel, tbl[i].e_field);
      chk($sformatf("t2[%0d] tick", i), tick_sec, tbl[i].e_tick);
    end

    // SET_MIN, bouncing up key then a 44-cycle hold.
    set_sw = 1'b1;
    cyc(1);
    press_next();
    chk("t3 field min", field_sel, 2);
    key_up = 1'b0; cyc(2);
    key_up = 1'b1; cyc(1);
    key_up = 1'b0; cyc(1);
    key_up = 1'b1; cyc(1);
    for (int c = 1; c <= 60; c++) begin
      key_up = (c <= 44) ? 1'b0 : 1'b1;
      cyc(1);
      exp_i = (c inside {7, 27, 32, 37, 42, 47});
      chk($sformatf("t3 inc c%0d", c), inc, exp_i);
      chk($sformatf("t3 dec c%0d", c), dec, 0);
    end

    // Up/down chord lockout, fresh re-press, then idle blink.
    bm = 1'b1;
    bc = 0;
    for (int c = 1; c <= 100; c++) begin
      key_up   = (c <= 40 || (c >= 61 && c <= 70)) ? 1'b0 : 1'b1;
      key_down = (c >= 8 && c <= 30) ? 1'b0 : 1'b1;
      cyc(1);
      exp_i = (c == 7 || c == 67);
      chk($sformatf("t4 inc c%0d", c), inc, exp_i);
      chk($sformatf("t4 dec c%0d", c), dec, 0);
      if (c >= 7) begin
        if (exp_i) begin
          bm = 1'b1;
          bc = 0;
        end else if (bc == BD - 1) begin
          bm = ~bm;
          bc = 0;
        end else begin
          bc++;
        end
        chk($sformatf("t5 blink c%0d", c), blink_on, bm);
      end
    end

    // Reset asserted between clock edges just before a repeat pulse in SET_SEC.
    press_next();
    chk("t6 field sec", field_sel, 1);
    for (int c = 1; c <= 26; c++) begin
      key_up = 1'b0;
      cyc(1);
      chk($sformatf("t6 inc c%0d", c), inc, (c == 7) ? 1 : 0);
    end
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("t6 async");
    key_up = 1'b1;
    cyc(1);
    chk_reset_vals("t6 held");
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    chk("t6 rel field", field_sel, 3);
    chk("t6 rel run", run, 0);
    chk("t6 rel blink", blink_on, 1);
    for (int c = 2; c <= 10; c++) begin
      cyc(1);
      chk($sformatf("t6 rel inc c%0d", c), inc, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
